// File: rtl/alu_op_issue_if.sv
// -----------------------------------------------------------------------------
// alu_op_issue_if
// Bundles the three signal groups around the ALU command-issue stage:
//   cmd_*  : producer -> issue stage command handshake (valid/ready, sel, a, b)
//   alu_*  : issue stage <-> combinational ALU (registered a/b/sel out, c back)
//   res_*  : issue stage -> consumer result handshake (valid/ready, data, sel,
//            illegal_op)
// Modports:
//   slave  : the issue stage itself
//   master : the surrounding environment (producer, ALU, consumer)
// Optional: when ALU_FLAGS_EN is defined, res_zero and res_ovf are added.
// -----------------------------------------------------------------------------
interface alu_op_issue_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_sel;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] alu_c;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [3:0]       res_sel;
    logic             illegal_op;
`ifdef ALU_FLAGS_EN
    logic             res_zero;
    logic             res_ovf;
`endif

    modport slave (
        input  cmd_valid, cmd_sel, cmd_a, cmd_b, alu_c, res_ready,
        output cmd_ready, alu_a, alu_b, alu_sel,
`ifdef ALU_FLAGS_EN
        output res_zero, res_ovf,
`endif
        output res_valid, res_data, res_sel, illegal_op
    );

    modport master (
        output cmd_valid, cmd_sel, cmd_a, cmd_b, alu_c, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel,
`ifdef ALU_FLAGS_EN
        input  res_zero, res_ovf,
`endif
        input  res_valid, res_data, res_sel, illegal_op
    );
endinterface

// File: rtl/alu_op_issue.sv
// -----------------------------------------------------------------------------
// alu_op_issue
// Command-issue stage in front of a WIDTH-bit combinational ALU. Commands
// {sel, a, b} are buffered in a DEPTH-entry FIFO, issued one at a time as
// registered operands, the ALU result is captured one cycle later and offered
// downstream until accepted. Issue is not overlapped: one result per 3 cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : alu_op_issue_if.slave (cmd_*, alu_*, res_* groups)
// Optional: define ALU_FLAGS_EN to add registered res_zero / res_ovf flags.
// -----------------------------------------------------------------------------
module alu_op_issue #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    alu_op_issue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    typedef struct packed {
        logic [3:0]       sel;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    cmd_t             r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_live;       // keeps cmd_ready low until after reset release
    state_t           r_state;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_sel;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic [3:0]       r_res_sel;
    logic             r_illegal;

    logic w_full;
    logic w_empty;
    logic w_cmd_ready;
    logic w_push;
    logic w_pop;

    function automatic logic f_illegal(input logic [3:0] sel);
        case (sel)
            4'b0000, 4'b1111, 4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0011, 4'b0110, 4'b1100, 4'b0101: return 1'b0;
            default:                                     return 1'b1;
        endcase
    endfunction

    assign w_full      = (r_count == (AW+1)'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_cmd_ready = r_live & ~w_full;
    assign w_push      = bus.cmd_valid & w_cmd_ready;
    assign w_pop       = (r_state == IDLE) & ~w_empty;

    // FIFO storage needs no reset: only entries counted in r_count are read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{sel: bus.cmd_sel, a: bus.cmd_a, b: bus.cmd_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_live   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    logic             r_res_zero;
    logic             r_res_ovf;
    logic [WIDTH:0]   w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic             w_ovf;

    assign w_sum  = {1'b0, r_alu_a} + {1'b0, r_alu_b};
    assign w_prod = (2*WIDTH)'(r_alu_a) * (2*WIDTH)'(r_alu_b);

    always_comb begin
        w_ovf = 1'b0;
        case (r_alu_sel)
            4'b0000: w_ovf = w_sum[WIDTH];
            4'b1111: w_ovf = (r_alu_a < r_alu_b);
            4'b0101: w_ovf = |w_prod[2*WIDTH-1:WIDTH];
            default: w_ovf = 1'b0;
        endcase
    end

    assign bus.res_zero = r_res_zero;
    assign bus.res_ovf  = r_res_ovf;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= 4'b0000;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_sel   <= 4'b0000;
            r_illegal   <= 1'b0;
`ifdef ALU_FLAGS_EN
            r_res_zero  <= 1'b0;
            r_res_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_alu_a   <= r_mem[r_rd_ptr].a;
                        r_alu_b   <= r_mem[r_rd_ptr].b;
                        r_alu_sel <= r_mem[r_rd_ptr].sel;
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    r_res_data  <= bus.alu_c;
                    r_res_sel   <= r_alu_sel;
                    r_illegal   <= f_illegal(r_alu_sel);
                    r_res_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
                    r_res_zero  <= (bus.alu_c == '0);
                    r_res_ovf   <= w_ovf;
`endif
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_sel    = r_alu_sel;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_data   = r_res_data;
    assign bus.res_sel    = r_res_sel;
    assign bus.illegal_op = r_illegal;
endmodule

// File: tb/tb_alu_op_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_op_issue
// Directed bench for alu_op_issue: supplies a combinational 4-bit ALU on the
// alu_* group, pushes commands, records accepted results, and compares them to
// hand-computed values. Flag checks are included when ALU_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_op_issue;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_op_issue_if #(.WIDTH(WIDTH)) bus ();

    alu_op_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Environment ALU; eq/gt return all-ones when true.
    always_comb begin
        bus.alu_c = '0;
        case (bus.alu_sel)
            4'b0000: bus.alu_c = bus.alu_a + bus.alu_b;
            4'b1111: bus.alu_c = bus.alu_a - bus.alu_b;
            4'b0001: bus.alu_c = bus.alu_a & bus.alu_b;
            4'b0010: bus.alu_c = bus.alu_a | bus.alu_b;
            4'b0100: bus.alu_c = bus.alu_a ^ bus.alu_b;
            4'b1000: bus.alu_c = (bus.alu_a == bus.alu_b) ? '1 : '0;
            4'b0011: bus.alu_c = (bus.alu_a > bus.alu_b) ? '1 : '0;
            4'b0110: bus.alu_c = bus.alu_a << bus.alu_b;
            4'b1100: bus.alu_c = bus.alu_a >> bus.alu_b;
            4'b0101: bus.alu_c = bus.alu_a * bus.alu_b;
            default: bus.alu_c = '0;
        endcase
    end

    typedef struct packed {
        logic [3:0] data;
        logic [3:0] sel;
        logic       ill;
        logic       zero;
        logic       ovf;
    } res_t;

    res_t q[$];
    res_t mon_r;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Record each result at the negedge preceding its accepting posedge.
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            mon_r.data = bus.res_data;
            mon_r.sel  = bus.res_sel;
            mon_r.ill  = bus.illegal_op;
`ifdef ALU_FLAGS_EN
            mon_r.zero = bus.res_zero;
            mon_r.ovf  = bus.res_ovf;
`else
            mon_r.zero = 1'b0;
            mon_r.ovf  = 1'b0;
`endif
            q.push_back(mon_r);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
        bit done;
        done = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_sel   = sel;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                tick();
                done = 1'b1;
            end
        end
        bus.cmd_valid = 1'b0;
        if (!done) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_results(input int n);
        for (int i = 0; i < 100; i++) begin
            if (q.size() >= n) break;
            tick();
        end
        check("res_count", q.size(), n);
    endtask

    // Stream vectors: {sel, a, b, expected}
    logic [3:0] s_sel [12] = '{4'b0000, 4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0011, 4'b0110, 4'b1100, 4'b0101, 4'b0000, 4'b1111};
    logic [3:0] s_a   [12] = '{9, 2, 12, 12, 10, 3, 7, 3, 13, 7, 4, 9};
    logic [3:0] s_b   [12] = '{8, 5, 10,  3,  6, 4, 2, 2,  1, 3, 4, 9};
    logic [3:0] s_exp [12] = '{1, 13, 8, 15, 12, 0, 15, 12, 6, 5, 8, 0};

    logic [3:0] b_sel [5] = '{4'b0101, 4'b0000, 4'b0001, 4'b0010, 4'b0100};
    logic [3:0] b_a   [5] = '{3, 1, 5, 8, 15};
    logic [3:0] b_b   [5] = '{5, 2, 6, 1, 5};
    logic [3:0] b_exp [5] = '{15, 3, 4, 9, 10};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_sel   = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.res_ready = 1'b0;
        rst = 1'b1;
        repeat (2) tick();

        // Reset state
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_b", bus.alu_b, 0);
        check("rst_alu_sel", bus.alu_sel, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_sel", bus.res_sel, 0);
        check("rst_illegal", bus.illegal_op, 0);
`ifdef ALU_FLAGS_EN
        check("rst_zero", bus.res_zero, 0);
        check("rst_ovf", bus.res_ovf, 0);
`endif
        rst = 1'b0;
        check("rel_ready_lo", bus.cmd_ready, 0);
        tick();
        check("rel_ready_hi", bus.cmd_ready, 1);

        // Single add with latency
        bus.res_ready = 1'b1;
        q.delete();
        push_cmd(4'b0000, 3, 4);
        check("add_v_e0", bus.res_valid, 0);
        tick();
        check("add_v_e1", bus.res_valid, 0);
        check("add_alu_a", bus.alu_a, 3);
        check("add_alu_b", bus.alu_b, 4);
        check("add_alu_sel", bus.alu_sel, 4'b0000);
        tick();
        check("add_v_e2", bus.res_valid, 1);
        check("add_data", bus.res_data, 7);
        check("add_sel", bus.res_sel, 4'b0000);
        check("add_ill", bus.illegal_op, 0);
        tick();
        check("add_v_e3", bus.res_valid, 0);
        check("add_hold_a", bus.alu_a, 3);

        // Backpressure: one in flight plus four buffered fills the stage
        bus.res_ready = 1'b0;
        q.delete();
        for (int i = 0; i < 5; i++) push_cmd(b_sel[i], b_a[i], b_b[i]);
        check("bp_full", bus.cmd_ready, 0);
        check("bp_sel", bus.res_sel, 4'b0101);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_v", bus.res_valid, 1);
            check("bp_hold_d", bus.res_data, 15);
            tick();
        end
        bus.res_ready = 1'b1;
        wait_results(5);
        for (int i = 0; i < 5 && i < q.size(); i++) begin
            check("bp_data", q[i].data, b_exp[i]);
            check("bp_rsel", q[i].sel, b_sel[i]);
        end

        // Streaming through pointer wrap
        q.delete();
        for (int i = 0; i < 12; i++) push_cmd(s_sel[i], s_a[i], s_b[i]);
        wait_results(12);
        for (int i = 0; i < 12 && i < q.size(); i++) begin
            check("st_data", q[i].data, s_exp[i]);
            check("st_rsel", q[i].sel, s_sel[i]);
            check("st_ill", q[i].ill, 0);
        end

        // Illegal opcode then eq
        q.delete();
        push_cmd(4'b0111, 9, 2);
        push_cmd(4'b1000, 6, 6);
        wait_results(2);
        if (q.size() >= 2) begin
            check("il_data", q[0].data, 0);
            check("il_sel", q[0].sel, 4'b0111);
            check("il_flag", q[0].ill, 1);
            check("eq_data", q[1].data, 15);
            check("eq_flag", q[1].ill, 0);
        end

        // Reset during EXEC with a second command buffered
        repeat (4) tick();
        q.delete();
        push_cmd(4'b0000, 1, 1);
        push_cmd(4'b0000, 2, 2);
        check("mid_alu_a", bus.alu_a, 1);
        rst = 1'b1;
        #1;
        check("mid_res_valid", bus.res_valid, 0);
        check("mid_cmd_ready", bus.cmd_ready, 0);
        check("mid_alu_a_clr", bus.alu_a, 0);
        tick();
        rst = 1'b0;
        tick();
        check("mid_ready_back", bus.cmd_ready, 1);
        repeat (10) tick();
        check("mid_no_result", q.size(), 0);
        check("mid_valid_lo", bus.res_valid, 0);
        check("mid_no_issue", bus.alu_a, 0);

`ifdef ALU_FLAGS_EN
        q.delete();
        push_cmd(4'b0000, 15, 1);
        push_cmd(4'b0101, 4, 4);
        wait_results(2);
        if (q.size() >= 2) begin
            check("fl_add_data", q[0].data, 0);
            check("fl_add_zero", q[0].zero, 1);
            check("fl_add_ovf", q[0].ovf, 1);
            check("fl_mul_data", q[1].data, 0);
            check("fl_mul_ovf", q[1].ovf, 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
